// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-flop synchroniser, idle qualification, mid-bit sampling.
// Build macro UART_RX_PARITY_EN adds a parity bit between data and stop (sense from ODD_PARITY).
module uart_rx_param #(
  parameter int CLK_DIV    = 5000,
  parameter int DATA_BITS  = 8,
  parameter int IDLE_BITS  = 12,
  parameter int ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 en_data_out,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int IW = $clog2(IDLE_BITS + 1);

  if (CLK_DIV < 8 || DATA_BITS < 5 || DATA_BITS > 9 || IDLE_BITS < 1 ||
      ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_bad_param
    $error("uart_rx_param: illegal parameter value");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s, rx_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idle_q, idle_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, dout_q, dout_d;
  logic                 en_q, en_d, ferr_q, ferr_d, perr_q, perr_d;
  logic                 tick;
`ifdef UART_RX_PARITY_EN
  logic                 pbad_q, pbad_d;
`endif

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= WAIT_IDLE;
      cnt_q     <= '0;
      idle_q    <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      dout_q    <= '0;
      en_q      <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], RX};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      dout_q    <= dout_d;
      en_q      <= en_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= pbad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    en_d    = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
`endif
    tick    = (cnt_q == CW'(CLK_DIV - 1));
    case (state_q)
      WAIT_IDLE: begin
        // any low sample restarts the whole idle qualification
        if (!rx_s) begin
          cnt_d  = '0;
          idle_d = '0;
        end else begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (tick) begin
            if (idle_q == IW'(IDLE_BITS - 1)) begin
              idle_d  = '0;
              state_d = IDLE;
            end else begin
              idle_d = idle_q + 1'b1;
            end
          end
        end
      end
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CW'(CLK_DIV / 2 - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          pbad_d  = ((^sh_q) ^ rx_s) != (ODD_PARITY != 0);
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          if (rx_s) begin
            dout_d  = sh_q;
            en_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = pbad_q;
`endif
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign data_out    = dout_q;
  assign en_data_out = en_q;
  assign frame_err   = ferr_q;
  assign parity_err  = perr_q;
  assign busy        = (state_q != WAIT_IDLE) && (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Random + directed frames against a line-level model; a monitor pops expected strobes from a queue.
module tb_uart_rx_param;
  localparam int CLK_DIV = 16, DATA_BITS = 8, IDLE_BITS = 12, ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // fall of start bit -> strobe visible: sync + half bit + data/parity/stop periods + output register
  localparam int LAT = 2 + CLK_DIV / 2 + CLK_DIV * (DATA_BITS + PB + 1) + 1;

  logic clk = 1'b0, res = 1'b1, RX = 1'b1;
  logic [DATA_BITS-1:0] data_out;
  logic en_data_out, frame_err, parity_err, busy;

  uart_rx_param #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .IDLE_BITS(IDLE_BITS),
                  .ODD_PARITY(ODD)) dut (
    .clk(clk), .res(res), .RX(RX), .data_out(data_out), .en_data_out(en_data_out),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic        is_data;
    logic [7:0]  data;
    logic        perr;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [7:0]  last_data = 8'h00;
  bit          qualified = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (en_data_out || frame_err) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: en=%0b ferr=%0b data=%0h, nothing expected (cycle %0d)",
                 en_data_out, frame_err, data_out, cyc);
      end else begin
        e = sb.pop_front();
        chk("strobe_is_data", en_data_out, e.is_data);
        chk("frame_err", frame_err, !e.is_data);
        chk("strobe_cycle", cyc, e.cyc);
        if (e.is_data) begin
          last_data = e.data;
          chk("parity_err", parity_err, e.perr);
        end
      end
    end else begin
      chk("parity_err_quiet", parity_err, 0);
    end
    chk("data_out", data_out, last_data);
  end

  task automatic wait_bit();
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) wait_bit();
    if (n > IDLE_BITS) qualified = 1;
  endtask

  // Sends one frame starting at a negedge; a qualified receiver reports it, otherwise it is ignored.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic pflip);
    exp_t e;
    logic pbit;
    pbit = (^d) ^ ODD[0] ^ pflip;
    if (qualified) begin
      e.is_data = stop_b;
      e.data    = d;
      e.perr    = (PB == 1) && pflip;
      e.cyc     = cyc + LAT;
      sb.push_back(e);
      if (!stop_b) qualified = 0;
    end
    RX = 1'b0;
    wait_bit();
    for (int i = 0; i < DATA_BITS; i++) begin
      RX = d[i];
      wait_bit();
    end
    if (PB == 1) begin
      RX = pbit;
      wait_bit();
    end
    RX = stop_b;
    wait_bit();
    RX = 1'b1;
  endtask

  initial begin
    #(80000 * 10);
    $display("FAIL timeout: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic stop_b, pflip;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_en", en_data_out, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_busy", busy, 0);
    res = 1'b0;
    idle(IDLE_BITS + 1);

    send_frame(8'hA5, 1'b1, 1'b0);
    idle(2);

    // short low glitch: false start
    RX = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    repeat (2) @(negedge clk);
    RX = 1'b1;
    repeat (6) @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    repeat (5) @(negedge clk);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(1);

    // bad stop, then a frame before idle re-qualification
    send_frame(8'h81, 1'b0, 1'b0);
    idle(1);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(IDLE_BITS + 1);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(1);

    if (PB == 1) begin
      send_frame(8'h07, 1'b1, 1'b1);
      send_frame(8'h07, 1'b1, 1'b0);
      idle(1);
    end

    // reset in the middle of data bit 4 of 0x55
    d = 8'h55;
    RX = 1'b0;
    wait_bit();
    for (int i = 0; i < 4; i++) begin
      RX = d[i];
      wait_bit();
    end
    RX = d[4];
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    res = 1'b1;
    last_data = 8'h00;
    qualified = 0;
    @(negedge clk);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_en", en_data_out, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_perr", parity_err, 0);
    chk("mid_rst_busy", busy, 0);
    res = 1'b0;
    repeat (7) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      RX = d[i];
      wait_bit();
    end
    RX = 1'b1;
    wait_bit();
    send_frame(8'h96, 1'b1, 1'b0);
    idle(IDLE_BITS + 1);
    send_frame(8'h96, 1'b1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 5) != 0);
      pflip  = 1'($urandom);
      send_frame(d, stop_b, pflip);
      if (!stop_b) begin
        if ($urandom_range(0, 1) == 1) begin
          idle(1);
          send_frame(8'($urandom), 1'b1, 1'b0);
        end
        idle(IDLE_BITS + 1);
      end else begin
        idle($urandom_range(0, 2));
      end
    end

    idle(2);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
